// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 target giving read/write access to NUM_REGS registers of DATA_W bits.
// Latency: pin edges seen 2-3 clk later; write commits 1 clk after the final-bit flag.
// Backpressure: none; the host paces frames and must respect the min sclk/cs timing.
//
// Ports:
//   clk, rst           system clock, synchronous active-high reset
//   sclk, COPI, cs     asynchronous SPI pins (cs active-low)
//   CIPO, cipo_oe      peripheral data out and its pad drive enable
//   regs_out           register i at [i*DATA_W +: DATA_W]
//   wr_stb, wr_addr    one-cycle write strobe and address of the latest committed write
//   frame_err          pulse on an aborted frame (cs rose before FRAME_W bits)
//   addr_err           pulse on a complete frame addressing >= NUM_REGS
//   err_cnt            saturating count of frame_err + addr_err pulses
module spi_regfile_peripheral #(
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sclk,
    input  logic                       COPI,
    input  logic                       cs,
    output logic                       CIPO,
    output logic                       cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs_out,
    output logic                       wr_stb,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic                       frame_err,
    output logic                       addr_err,
    output logic [7:0]                 err_cnt
);

    localparam int FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    // Shift window only needs to hold the wider of {rw,addr} and data.
    localparam int SH_W    = (ADDR_W + 1 > DATA_W) ? ADDR_W + 1 : DATA_W;

    localparam logic [CNT_W-1:0]  CMD_LAST   = CNT_W'(ADDR_W);
    localparam logic [CNT_W-1:0]  FRAME_LAST = CNT_W'(FRAME_W - 1);
    localparam logic [ADDR_W:0]   NUM_REGS_A = (ADDR_W + 1)'(NUM_REGS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMD,
        S_DATA,
        S_DONE
    } state_t;

    // Synchronisers plus previous-value flops for edge detection.
    logic sclk_s1, sclk_s2, sclk_prev;
    logic copi_s1, copi_s2;
    logic cs_s1, cs_s2, cs_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_s1   <= 1'b0;
            sclk_s2   <= 1'b0;
            sclk_prev <= 1'b0;
            copi_s1   <= 1'b0;
            copi_s2   <= 1'b0;
            cs_s1     <= 1'b1;
            cs_s2     <= 1'b1;
            cs_prev   <= 1'b1;
        end else begin
            sclk_s1   <= sclk;
            sclk_s2   <= sclk_s1;
            sclk_prev <= sclk_s2;
            copi_s1   <= COPI;
            copi_s2   <= copi_s1;
            cs_s1     <= cs;
            cs_s2     <= cs_s1;
            cs_prev   <= cs_s2;
        end
    end

    logic sclk_rise, sclk_fall, cs_fall, cs_rise;
    assign sclk_rise = sclk_s2 & ~sclk_prev;
    assign sclk_fall = ~sclk_s2 & sclk_prev;
    assign cs_fall   = ~cs_s2 & cs_prev;
    assign cs_rise   = cs_s2 & ~cs_prev;

    state_t              state_q, state_n;
    logic [CNT_W-1:0]    bit_cnt_q;
    logic [SH_W-2:0]     shift_q;
    logic [SH_W-1:0]     shift_n;
    logic                rw_q;        // 1 = write
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   out_shift_q;
    logic                commit_q;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];

    logic start, shift_en, capture, finish, abort;

    assign shift_n = {shift_q, copi_s2};

    // ---------------- FSM: next state and control strobes ----------------
    always_comb begin
        state_n  = state_q;
        start    = 1'b0;
        shift_en = 1'b0;
        capture  = 1'b0;
        finish   = 1'b0;
        abort    = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Any sclk flag in this cycle is intentionally not sampled.
                if (cs_fall) begin
                    start   = 1'b1;
                    state_n = S_CMD;
                end
            end
            S_CMD: begin
                if (cs_rise) begin
                    abort   = 1'b1;
                    state_n = S_IDLE;
                end else if (sclk_rise) begin
                    shift_en = 1'b1;
                    if (bit_cnt_q == CMD_LAST) begin
                        capture = 1'b1;
                        state_n = S_DATA;
                    end
                end
            end
            S_DATA: begin
                // A final bit arriving with cs rising still completes the frame.
                if (sclk_rise && bit_cnt_q == FRAME_LAST) begin
                    shift_en = 1'b1;
                    finish   = 1'b1;
                    state_n  = S_DONE;
                end else if (cs_rise) begin
                    abort   = 1'b1;
                    state_n = S_IDLE;
                end else if (sclk_rise) begin
                    shift_en = 1'b1;
                end
            end
            S_DONE: begin
                // Level test so a cs rise coinciding with the final bit is not missed.
                if (cs_s2) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // ---------------- Read data selection ----------------
    logic [ADDR_W-1:0] cap_addr;
    logic              cap_rw;
    logic [DATA_W-1:0] rd_word;

    assign cap_addr = shift_n[ADDR_W-1:0];
    assign cap_rw   = shift_n[ADDR_W];

    // Out-of-range addresses match no entry and read as zero.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (cap_addr == ADDR_W'(i)) begin
                rd_word = regs_q[i];
            end
        end
    end

    logic addr_ok;
    assign addr_ok = ({1'b0, addr_q} < NUM_REGS_A);

    logic rw_n, oe_n;
    assign rw_n = capture ? cap_rw : rw_q;
    assign oe_n = ((state_n == S_DATA) || (state_n == S_DONE)) && !rw_n && !cs_s2;

    logic [8:0] err_sum;
    assign err_sum = {1'b0, err_cnt} + 9'(frame_err) + 9'(addr_err);

    // ---------------- Datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            out_shift_q <= '0;
            commit_q    <= 1'b0;
            CIPO        <= 1'b0;
            cipo_oe     <= 1'b0;
            wr_stb      <= 1'b0;
            wr_addr     <= '0;
            frame_err   <= 1'b0;
            addr_err    <= 1'b0;
            err_cnt     <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (start) begin
                shift_q   <= '0;
                bit_cnt_q <= '0;
            end else if (shift_en) begin
                shift_q   <= shift_n[SH_W-2:0];
                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end

            if (capture) begin
                rw_q        <= cap_rw;
                addr_q      <= cap_addr;
                out_shift_q <= cap_rw ? '0 : rd_word;
            end else if (state_q == S_DATA && sclk_fall && !rw_q) begin
                out_shift_q <= out_shift_q << 1;
            end

            if (finish) begin
                wdata_q <= shift_n[DATA_W-1:0];
            end

            cipo_oe <= oe_n;
            if (!oe_n) begin
                CIPO <= 1'b0;
            end else if (state_q == S_DATA && sclk_fall) begin
                CIPO <= out_shift_q[DATA_W-1];
            end

            commit_q  <= finish;
            wr_stb    <= 1'b0;
            addr_err  <= 1'b0;
            frame_err <= abort;
            if (commit_q) begin
                if (!addr_ok) begin
                    addr_err <= 1'b1;
                end else if (rw_q) begin
                    wr_stb  <= 1'b1;
                    wr_addr <= addr_q;
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (addr_q == ADDR_W'(i)) begin
                            regs_q[i] <= wdata_q;
                        end
                    end
                end
            end

            err_cnt <= err_sum[8] ? 8'hFF : err_sum[7:0];
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
        assign regs_out[g*DATA_W +: DATA_W] = regs_q[g];
    end

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Self-checking bench: directed frames from the test plan plus random frames
// checked against a register-array model of the SPI register file.
module tb_spi_regfile_peripheral;

    localparam int HP = 6;   // sclk half period in clk cycles

    logic        clk = 1'b0;
    logic        rst;
    logic        sclk;
    logic        copi;
    logic        cs;
    logic        cipo;
    logic        cipo_oe;
    logic [39:0] regs_out;
    logic        wr_stb;
    logic [6:0]  wr_addr;
    logic        frame_err;
    logic        addr_err;
    logic [7:0]  err_cnt;

    spi_regfile_peripheral #(.ADDR_W(7), .DATA_W(8), .NUM_REGS(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .sclk      (sclk),
        .COPI      (copi),
        .cs        (cs),
        .CIPO      (cipo),
        .cipo_oe   (cipo_oe),
        .regs_out  (regs_out),
        .wr_stb    (wr_stb),
        .wr_addr   (wr_addr),
        .frame_err (frame_err),
        .addr_err  (addr_err),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pulse monitor
    int         n_stb = 0, n_ferr = 0, n_aerr = 0;
    logic [6:0] last_waddr = '0;
    always @(negedge clk) begin
        if (wr_stb) begin
            n_stb++;
            last_waddr = wr_addr;
        end
        if (frame_err) n_ferr++;
        if (addr_err)  n_aerr++;
    end

    // Reference model
    logic [7:0] mreg [5];
    int         m_err;

    function automatic logic [39:0] exp_regs();
        logic [39:0] r;
        for (int i = 0; i < 5; i++) r[i*8 +: 8] = mreg[i];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 5; i++) mreg[i] = '0;
        m_err = 0;
    endtask

    // Sends the first nbits of frm, sampling CIPO just before each rising sclk.
    // bad counts bit slots where cipo_oe differed from the expected read window
    // or CIPO was driven while cipo_oe was low.
    task automatic spi_xfer(input logic [15:0] frm, input int nbits, input int gap,
                            output logic [7:0] rd, output int bad);
        logic exp_oe;
        rd  = '0;
        bad = 0;
        cs  = 1'b0;
        repeat (6) @(posedge clk);
        for (int i = 0; i < nbits; i++) begin
            copi = frm[15-i];
            repeat (HP) @(posedge clk);
            #1;
            exp_oe = (i >= 8) && !frm[15];
            if (cipo_oe !== exp_oe) bad++;
            if (!cipo_oe && cipo !== 1'b0) bad++;
            if (i >= 8) rd = {rd[6:0], cipo};
            sclk = 1'b1;
            repeat (HP) @(posedge clk);
            sclk = 1'b0;
        end
        repeat (6) @(posedge clk);
        copi = 1'b0;
        cs   = 1'b1;
        repeat (gap) @(posedge clk);
    endtask

    task automatic do_frame(input string tag, input logic rw, input logic [6:0] addr,
                            input logic [7:0] data, input int nbits, input int gap,
                            input bit check, output logic [7:0] rd);
        int   s0, f0, a0, bad;
        int   exp_stb, exp_f, exp_a;
        logic [7:0] exp_rd;
        s0 = n_stb; f0 = n_ferr; a0 = n_aerr;
        exp_stb = 0; exp_f = 0; exp_a = 0; exp_rd = '0;
        if (nbits < 16) begin
            exp_f = 1;
        end else if (addr >= 7'd5) begin
            exp_a = 1;
        end else if (rw) begin
            mreg[int'(addr)] = data;
            exp_stb = 1;
        end else begin
            exp_rd = mreg[int'(addr)];
        end
        m_err = m_err + exp_f + exp_a;
        if (m_err > 255) m_err = 255;

        spi_xfer({rw, addr, data}, nbits, gap, rd, bad);

        if (check) begin
            repeat (8) @(posedge clk);
            #1;
            check_eq({tag, ".regs"},    regs_out, exp_regs());
            check_eq({tag, ".err_cnt"}, err_cnt, m_err);
            check_eq({tag, ".n_stb"},   n_stb - s0, exp_stb);
            check_eq({tag, ".n_ferr"},  n_ferr - f0, exp_f);
            check_eq({tag, ".n_aerr"},  n_aerr - a0, exp_a);
            check_eq({tag, ".oe_shape"}, bad, 0);
            check_eq({tag, ".oe_after"}, {cipo_oe, cipo}, 2'b00);
            if (exp_stb != 0) check_eq({tag, ".wr_addr"}, last_waddr, addr);
            if (!rw && nbits == 16) check_eq({tag, ".rdata"}, rd, exp_rd);
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;
        int s0, f0, a0;

        rst = 1'b1; sclk = 1'b0; copi = 1'b0; cs = 1'b1;
        model_reset();
        repeat (5) @(posedge clk);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check_eq("rst.regs",      regs_out, 40'h0);
        check_eq("rst.cipo",      cipo, 1'b0);
        check_eq("rst.cipo_oe",   cipo_oe, 1'b0);
        check_eq("rst.wr_stb",    wr_stb, 1'b0);
        check_eq("rst.wr_addr",   wr_addr, 7'h0);
        check_eq("rst.frame_err", frame_err, 1'b0);
        check_eq("rst.addr_err",  addr_err, 1'b0);
        check_eq("rst.err_cnt",   err_cnt, 8'h0);

        // Write 0x84A5, then read it back with 0x0400.
        do_frame("wr84A5", 1'b1, 7'd4, 8'hA5, 16, 10, 1'b1, rd);
        check_eq("wr84A5.reg4", regs_out[39:32], 8'hA5);
        do_frame("rd0400", 1'b0, 7'd4, 8'h00, 16, 10, 1'b1, rd);
        check_eq("rd0400.bits", rd, 8'hA5);

        // Out-of-range write to address 10.
        do_frame("wr8A3C", 1'b1, 7'd10, 8'h3C, 16, 10, 1'b1, rd);
        check_eq("wr8A3C.err_cnt", err_cnt, 8'd1);

        // Abort after 9 bits, then a full write to the same register.
        do_frame("abort81FF", 1'b1, 7'd1, 8'hFF, 9, 10, 1'b1, rd);
        do_frame("wr8133", 1'b1, 7'd1, 8'h33, 16, 10, 1'b1, rd);
        check_eq("wr8133.reg1", regs_out[15:8], 8'h33);

        // Reset during bit 12 of 0x8077.
        s0 = n_stb; f0 = n_ferr; a0 = n_aerr;
        begin
            logic [15:0] frm;
            frm = 16'h8077;
            cs = 1'b0;
            repeat (6) @(posedge clk);
            for (int i = 0; i < 12; i++) begin
                copi = frm[15-i];
                repeat (HP) @(posedge clk);
                if (i == 11) begin
                    rst = 1'b1;
                    repeat (3) @(posedge clk);
                    cs = 1'b1; sclk = 1'b0; copi = 1'b0;
                    repeat (3) @(posedge clk);
                    rst = 1'b0;
                end else begin
                    sclk = 1'b1;
                    repeat (HP) @(posedge clk);
                    sclk = 1'b0;
                end
            end
        end
        model_reset();
        repeat (20) @(posedge clk);
        #1;
        check_eq("rstmid.regs",    regs_out, exp_regs());
        check_eq("rstmid.err_cnt", err_cnt, 8'd0);
        check_eq("rstmid.pulses",  (n_stb - s0) + (n_ferr - f0) + (n_aerr - a0), 0);

        // Back-to-back writes with a 4-clk cs-high gap.
        s0 = n_stb;
        for (int i = 0; i < 5; i++) begin
            do_frame("b2b", 1'b1, 7'(i), 8'(8'h11 * (i + 3)), 16, 4, 1'b0, rd);
        end
        repeat (12) @(posedge clk);
        #1;
        check_eq("b2b.regs",  regs_out, exp_regs());
        check_eq("b2b.n_stb", n_stb - s0, 5);

        // Random frames: mixed reads/writes, in/out of range, some aborted.
        for (int k = 0; k < 40; k++) begin
            logic       rw;
            logic [6:0] addr;
            logic [7:0] data;
            int         nbits;
            rw    = 1'($urandom_range(0, 1));
            addr  = 7'($urandom_range(0, 7));
            data  = 8'($urandom);
            nbits = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 15) : 16;
            do_frame($sformatf("rnd%0d", k), rw, addr, data, nbits,
                     $urandom_range(4, 8), 1'b1, rd);
        end

        // Saturation: 260 aborted frames.
        f0 = n_ferr;
        for (int i = 0; i < 260; i++) begin
            do_frame("sat", 1'b1, 7'd0, 8'h00, 0, 8, 1'b0, rd);
        end
        repeat (10) @(posedge clk);
        #1;
        check_eq("sat.err_cnt", err_cnt, m_err);
        check_eq("sat.is_255",  err_cnt, 8'd255);
        check_eq("sat.n_ferr",  n_ferr - f0, 260);
        check_eq("sat.regs",    regs_out, exp_regs());

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_regfile_peripheral.md
# spi_regfile_peripheral

Parametrised SPI (mode 0, MSB-first) target that gives the host read and write access to a bank of `NUM_REGS` configuration registers of `DATA_W` bits. It replaces the write-only five-register SPI interface. It adds read-back over CIPO, parametrised address and data widths, a write strobe for downstream logic, and error reporting for aborted frames and out-of-range addresses. All SPI pins are asynchronous to `clk` and are synchronised internally.

## Interface
- `ADDR_W`, 7: address field width; must satisfy 2^ADDR_W ≥ NUM_REGS.
- `DATA_W`, 8: register and data-field width.
- `NUM_REGS`, 5: number of implemented registers, 1..2^ADDR_W.
- `clk` input 1: system clock; the block's only clock.
- `rst` input 1: reset, synchronous and active-high.
- `sclk` input 1: SPI clock, asynchronous.
- `COPI` input 1: controller-out data, asynchronous.
- `cs` input 1: chip select, active-low, asynchronous.
- `CIPO` output 1: peripheral-out data.
- `cipo_oe` output 1: CIPO drive enable for the pad.
- `regs_out` output NUM_REGS*DATA_W: register i is at `[i*DATA_W +: DATA_W]`.
- `wr_stb` output 1: one-cycle pulse when a register is written.
- `wr_addr` output ADDR_W: address of the most recent committed write.
- `frame_err` output 1: one-cycle pulse when a frame is aborted.
- `addr_err` output 1: one-cycle pulse when a complete frame targets address ≥ NUM_REGS.
- `err_cnt` output 8: saturating count of frame_err plus addr_err events.

## Operation
- **Frame format:** FRAME_W = 1+ADDR_W+DATA_W bits, MSB first.
  - Bit order: R/W̄ (1 = write, 0 = read), then address, then data.
  - With default parameters, write 0x04 = 0xA5 is sent as 0x84A5.
- **Synchroniser:** `sclk`, `COPI` and `cs` each pass through 2 flops.
  - A previous-value flop on synced `sclk` and on synced `cs` provides edge detection.
  - Synchroniser reset values: sclk 0, COPI 0, cs 1.
- **Frame state machine:** IDLE → CMD → DATA → DONE.
  - IDLE: synced cs high. A cs falling edge clears the shift register and bit counter and enters CMD.
  - CMD: shift COPI in on each synced sclk rising edge. After 1+ADDR_W bits, latch R/W̄ and address and enter DATA.
  - On entering DATA for a read: load the output shifter with reg[addr], or all-zeros if addr ≥ NUM_REGS.
  - DATA: keep shifting. After DATA_W more bits, enter DONE.
  - DONE: further sclk edges are ignored until cs rises. cs rising returns to IDLE.
- **Write commit:** happens on the clk edge after the cycle in which the final bit was shifted.
  - If addr < NUM_REGS: the register updates, `wr_stb`=1 and `wr_addr`=addr on that same edge.
  - Otherwise: no register changes and `addr_err` pulses.
- **Read:**
  - `cipo_oe`=1 only in DATA/DONE of a read frame while synced cs is low.
  - On each synced sclk falling edge in DATA, the output shifter advances and `CIPO` presents the next bit. The first falling edge after address capture presents the data MSB.
  - A read from addr ≥ NUM_REGS returns zeros and pulses `addr_err` at frame completion.
  - A read never modifies any register.
  - `CIPO`=0 whenever `cipo_oe`=0.
- **Abort:** cs rises in CMD or DATA, i.e. before FRAME_W bits.
  - The frame is discarded with no write and no `wr_stb`.
  - `frame_err` pulses one cycle after cs_rise is detected. The state returns to IDLE.
- **Error counter:** `err_cnt` increments by 1 per error pulse and saturates at 255.

## Timing
- **Reset values:**
  - `rst`=1 at a clk edge: every register 0, `regs_out`=0, `CIPO`=0, `cipo_oe`=0, `wr_stb`=0, `wr_addr`=0, `frame_err`=0, `addr_err`=0, `err_cnt`=0, state IDLE.
  - `rst` has priority over all SPI activity.
  - Reset mid-frame discards the frame with no commit and no error pulse. A new frame needs a fresh cs falling edge after `rst` deasserts.
- **Edge latency:** an sclk or cs pin edge is seen as an edge flag 2–3 clk cycles after it occurs at the pin.
  - Write latency: register valid 1 clk after the final-bit edge flag.
  - `sclk` high and low phases must each be ≥ 4 clk periods. cs setup and hold around sclk edges must be ≥ 4 clk periods.
- **Simultaneous events:**
  - Final-bit sclk flag and cs rising flag in the same cycle: the frame completes and commits normally, with no `frame_err`.
  - cs falling flag together with an sclk rising flag: cs wins and that sclk edge is not sampled.
- **Output characteristics:** all outputs are registered. `wr_stb`, `frame_err` and `addr_err` never exceed one cycle per frame.

## Test plan
- **Reset:** reset, then idle 20 cycles → all outputs 0, `cipo_oe`=0.
- **Write then read-back:** write 0x84A5, then read 0x0400 → `regs_out[39:32]`=0xA5 and `wr_stb` once with `wr_addr`=4; read shifts out 10100101 on CIPO with `cipo_oe` high only during the 8 data bits.
- **Out-of-range write:** write 0x8A3C (addr 10) → no register changes, no `wr_stb`, `addr_err` once, `err_cnt`=1.
- **Aborted frame:** cs rises after 9 bits of 0x81FF → register 1 unchanged, `frame_err` once, `err_cnt` increments. A following full write 0x8133 → register 1 = 0x33.
- **Reset mid-frame and saturation:** `rst` during bit 12 of 0x8077 → register 0 stays 0 and no error pulse. Then 260 aborted frames → `err_cnt` holds at 255.
- **Back-to-back writes:** writes to registers 0..4 with minimum cs-high gap (4 clk) → each commits the correct value, with exactly 5 `wr_stb` pulses.
